// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/data/grant bundle between four requesters, the arbiter and the shared sink
interface mux4_rr_arbiter_if #(
  parameter int W = 1
);
  logic [3:0]     req;
  logic [3:0]     last;
  logic [4*W-1:0] in_data;
  logic           out_tready;
  logic [1:0]     sel;
  logic [3:0]     grant;
  logic           out_tvalid;
  logic [W-1:0]   out_tdata;
  logic           busy;

  modport master (
    output req, last, in_data, out_tready,
    input  sel, grant, out_tvalid, out_tdata, busy
  );

  modport slave (
    input  req, last, in_data, out_tready,
    output sel, grant, out_tvalid, out_tdata, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin burst arbiter owning a shared 4:1 mux select with a valid/ready output
module mux4_rr_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mux4_rr_arbiter_if.slave arb
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic [3:0] grant_q;
  logic [3:0] beat_cnt_q;
  logic       busy_q;

  logic [1:0] pick_d;
  logic       pick_vld_d;
  logic       out_valid;
  logic       xfer;
  logic       rel;

  // Scan from the highest offset down so the channel closest to ptr wins.
  always_comb begin
    pick_d     = 2'd0;
    pick_vld_d = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (arb.req[ptr_q + 2'(k)]) begin
        pick_d     = ptr_q + 2'(k);
        pick_vld_d = 1'b1;
      end
    end
  end

  assign out_valid = (state_q == BUSY) && arb.req[sel_q];
  assign xfer      = out_valid && arb.out_tready;
  assign rel       = (xfer && (arb.last[sel_q] || (beat_cnt_q == LAST_BEAT)))
                   || ((state_q == BUSY) && !arb.req[sel_q]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      grant_q    <= 4'b0000;
      beat_cnt_q <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q    <= BUSY;
            sel_q      <= pick_d;
            grant_q    <= 4'b0001 << pick_d;
            beat_cnt_q <= 4'd0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          // S is left alone on release so the mux keeps pointing at the last owner.
          if (rel) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + 2'd1;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arb.sel        = sel_q;
  assign arb.grant      = grant_q;
  assign arb.busy       = busy_q;
  assign arb.out_tvalid = out_valid;
  assign arb.out_tdata  = arb.in_data[sel_q*W +: W];

endmodule
